// File: rtl/gt_bringup_pkg.sv
// Shared definitions for the GT lane bring-up sequencer.
//   - bringup_state_e : sequencer states; the encoding is visible on STATE_O
//   - lane_count()    : lanes per configuration (four lanes per quad)
//   - timer_width()   : width of the state timer, large enough for either timeout
package gt_bringup_pkg;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StWaitRefclk = 3'd1,
        StPllRst     = 3'd2,
        StWaitLock   = 3'd3,
        StGtRst      = 3'd4,
        StWaitDone   = 3'd5,
        StRun        = 3'd6,
        StFail       = 3'd7
    } bringup_state_e;

    localparam int unsigned LANES_PER_QUAD = 4;

    function automatic int unsigned lane_count(input int unsigned num_quads);
        return LANES_PER_QUAD * num_quads;
    endfunction

    function automatic int unsigned timer_width(input int unsigned lock_to,
                                                input int unsigned done_to);
        int unsigned m;
        m = (lock_to > done_to) ? lock_to : done_to;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/refclk_activity_mon.sv
// Activity monitor for one divided, already-synchronised refclk toggle.
// Counts toggle edges over a free-running window of WIN cycles and reports
// whether at least MIN_EDGES edges were seen in the last complete window.
//   clk_i  : system clock
//   rst_i  : synchronous reset, active-high
//   tgl_i  : refclk toggle (synchronous to clk_i)
//   ok_o   : registered activity status, updated once per window
module refclk_activity_mon #(
    parameter int unsigned WIN       = 1024,
    parameter int unsigned MIN_EDGES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tgl_i,
    output logic ok_o
);

    localparam int unsigned WW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned CW = $clog2(MIN_EDGES + 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MIN_EDGES);

    logic          tgl_q;
    logic [WW-1:0] win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ok_q, ok_d;
    logic          edge_seen;
    logic          wrap;

    always_comb begin
        edge_seen = tgl_i ^ tgl_q;
        wrap      = (win_q == WIN_LAST);
        win_d     = wrap ? '0 : win_q + WW'(1);
        ok_d      = ok_q;
        cnt_d     = cnt_q;
        if (wrap) begin
            ok_d  = (cnt_q >= CNT_MAX);
            // An edge landing in the wrap cycle belongs to the new window.
            cnt_d = CW'(edge_seen);
        end else if (edge_seen && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tgl_q <= 1'b0;
            win_q <= '0;
            cnt_q <= '0;
            ok_q  <= 1'b0;
        end else begin
            tgl_q <= tgl_i;
            win_q <= win_d;
            cnt_q <= cnt_d;
            ok_q  <= ok_d;
        end
    end

    assign ok_o = ok_q;

endmodule

// File: rtl/gt_lane_bringup_ctrl.sv
// Bring-up sequencer for 7-series GT quads: checks refclk activity, pulses and
// waits on PLL reset/lock, pulses and waits on GT reset/resetdone, then enables
// TX on the lanes selected by the latched mask. Timeouts and loss of lock or
// refclk in RUN trigger bounded retries before latching FAIL.
//   SYSCLK_I      : system clock, all logic in this domain
//   RST_I         : synchronous reset, active-high
//   START_I       : level request; low returns to IDLE
//   LANE_MASK_I   : lanes to bring up, latched when leaving IDLE
//   REFCLK_TGL_I  : divided refclk toggles (synchronised)
//   PLL_LOCK_I    : per-quad PLL lock
//   RESETDONE_I   : per-lane GT resetdone
//   PLL_RESET_O   : per-quad PLL reset
//   GT_RESET_O    : per-lane GT reset
//   TX_EN_O       : per-lane TX enable
//   STATE_O       : current state encoding
//   READY_O       : high in RUN
//   FAIL_O        : high in FAIL
//   RETRY_CNT_O   : retries used
//   REFCLK_OK_O   : per-refclk activity status
module gt_lane_bringup_ctrl
    import gt_bringup_pkg::*;
#(
    parameter int unsigned NUM_QUADS        = 1,
    parameter int unsigned NUM_REFCLKS      = 1,
    parameter int unsigned REFCLK_WIN       = 1024,
    parameter int unsigned REFCLK_MIN_EDGES = 16,
    parameter int unsigned RST_CYC          = 16,
    parameter int unsigned LOCK_TIMEOUT     = 65536,
    parameter int unsigned DONE_TIMEOUT     = 65536,
    parameter int unsigned MAX_RETRY        = 3
) (
    input  logic                     SYSCLK_I,
    input  logic                     RST_I,
    input  logic                     START_I,
    input  logic [4*NUM_QUADS-1:0]   LANE_MASK_I,
    input  logic [NUM_REFCLKS-1:0]   REFCLK_TGL_I,
    input  logic [NUM_QUADS-1:0]     PLL_LOCK_I,
    input  logic [4*NUM_QUADS-1:0]   RESETDONE_I,
    output logic [NUM_QUADS-1:0]     PLL_RESET_O,
    output logic [4*NUM_QUADS-1:0]   GT_RESET_O,
    output logic [4*NUM_QUADS-1:0]   TX_EN_O,
    output logic [2:0]               STATE_O,
    output logic                     READY_O,
    output logic                     FAIL_O,
    output logic [3:0]               RETRY_CNT_O,
    output logic [NUM_REFCLKS-1:0]   REFCLK_OK_O
);

    localparam int unsigned NL = lane_count(NUM_QUADS);
    localparam int unsigned TW = timer_width(LOCK_TIMEOUT, DONE_TIMEOUT);
    localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYC - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] DONE_LAST = TW'(DONE_TIMEOUT - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    logic [NUM_REFCLKS-1:0] refclk_ok;

    for (genvar r = 0; r < NUM_REFCLKS; r++) begin : g_refclk_mon
        refclk_activity_mon #(
            .WIN       (REFCLK_WIN),
            .MIN_EDGES (REFCLK_MIN_EDGES)
        ) u_mon (
            .clk_i (SYSCLK_I),
            .rst_i (RST_I),
            .tgl_i (REFCLK_TGL_I[r]),
            .ok_o  (refclk_ok[r])
        );
    end

    bringup_state_e   state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [3:0]       retry_q, retry_d;
    logic [NL-1:0]    mask_q, mask_d;
    logic [NUM_QUADS-1:0] pll_rst_q, pll_rst_d;
    logic [NL-1:0]    gt_rst_q, gt_rst_d;
    logic [NL-1:0]    tx_en_q, tx_en_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    logic all_ok;
    logic all_lock;
    logic done_met;
    logic retry_req;

    always_comb begin
        all_ok    = &refclk_ok;
        all_lock  = &PLL_LOCK_I;
        done_met  = ((RESETDONE_I & mask_q) == mask_q);

        state_d   = state_q;
        timer_d   = (&timer_q) ? timer_q : timer_q + TW'(1);
        retry_d   = retry_q;
        mask_d    = mask_q;
        retry_req = 1'b0;

        if (!START_I) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    mask_d  = LANE_MASK_I;
                    state_d = StWaitRefclk;
                end
                StWaitRefclk: if (all_ok) state_d = StPllRst;
                StPllRst:     if (timer_q == RST_LAST) state_d = StWaitLock;
                StWaitLock: begin
                    if (all_lock)                    state_d   = StGtRst;
                    else if (timer_q == LOCK_LAST)   retry_req = 1'b1;
                end
                StGtRst:      if (timer_q == RST_LAST) state_d = StWaitDone;
                StWaitDone: begin
                    if (done_met)                    state_d   = StRun;
                    else if (timer_q == DONE_LAST)   retry_req = 1'b1;
                end
                StRun:        if (!all_lock || !all_ok) retry_req = 1'b1;
                StFail:       ;
                default:      state_d = StIdle;
            endcase
        end

        if (retry_req) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                state_d = StPllRst;
            end else begin
                state_d = StFail;
            end
        end

        if (state_d == StIdle) retry_d = '0;
        if (state_d != state_q) timer_d = '0;

        // Outputs are decoded from the next state so they register in step with STATE_O.
        pll_rst_d = '1;
        gt_rst_d  = '1;
        tx_en_d   = '0;
        ready_d   = 1'b0;
        fail_d    = 1'b0;
        unique case (state_d)
            StWaitLock, StGtRst: begin
                // In GT_RST masked lanes get their pulse; unmasked lanes are held anyway.
                pll_rst_d = '0;
            end
            StWaitDone: begin
                pll_rst_d = '0;
                gt_rst_d  = ~mask_d;
            end
            StRun: begin
                pll_rst_d = '0;
                gt_rst_d  = ~mask_d;
                tx_en_d   = mask_d;
                ready_d   = 1'b1;
            end
            StFail:  fail_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge SYSCLK_I) begin
        if (RST_I) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            retry_q   <= '0;
            mask_q    <= '0;
            pll_rst_q <= '1;
            gt_rst_q  <= '1;
            tx_en_q   <= '0;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            mask_q    <= mask_d;
            pll_rst_q <= pll_rst_d;
            gt_rst_q  <= gt_rst_d;
            tx_en_q   <= tx_en_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign PLL_RESET_O = pll_rst_q;
    assign GT_RESET_O  = gt_rst_q;
    assign TX_EN_O     = tx_en_q;
    assign STATE_O     = state_q;
    assign READY_O     = ready_q;
    assign FAIL_O      = fail_q;
    assign RETRY_CNT_O = retry_q;
    assign REFCLK_OK_O = refclk_ok;

endmodule

// File: tb/tb_gt_lane_bringup_ctrl.sv
module tb_gt_lane_bringup_ctrl;

    localparam int NQ   = 1;
    localparam int NR   = 2;
    localparam int NLB  = 4;
    localparam int WIN  = 64;
    localparam int MINE = 8;
    localparam int RSTC = 16;
    localparam int LTO  = 200;
    localparam int DTO  = 150;
    localparam int MAXR = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [NLB-1:0] mask_in;
    logic [NR-1:0]  tgl;
    logic [NQ-1:0]  lock;
    logic [NLB-1:0] done;

    logic [NQ-1:0]  PLL_RESET_O;
    logic [NLB-1:0] GT_RESET_O;
    logic [NLB-1:0] TX_EN_O;
    logic [2:0]     STATE_O;
    logic           READY_O;
    logic           FAIL_O;
    logic [3:0]     RETRY_CNT_O;
    logic [NR-1:0]  REFCLK_OK_O;

    always #5 clk = ~clk;

    gt_lane_bringup_ctrl #(
        .NUM_QUADS        (NQ),
        .NUM_REFCLKS      (NR),
        .REFCLK_WIN       (WIN),
        .REFCLK_MIN_EDGES (MINE),
        .RST_CYC          (RSTC),
        .LOCK_TIMEOUT     (LTO),
        .DONE_TIMEOUT     (DTO),
        .MAX_RETRY        (MAXR)
    ) dut (
        .SYSCLK_I     (clk),
        .RST_I        (rst),
        .START_I      (start),
        .LANE_MASK_I  (mask_in),
        .REFCLK_TGL_I (tgl),
        .PLL_LOCK_I   (lock),
        .RESETDONE_I  (done),
        .PLL_RESET_O  (PLL_RESET_O),
        .GT_RESET_O   (GT_RESET_O),
        .TX_EN_O      (TX_EN_O),
        .STATE_O      (STATE_O),
        .READY_O      (READY_O),
        .FAIL_O       (FAIL_O),
        .RETRY_CNT_O  (RETRY_CNT_O),
        .REFCLK_OK_O  (REFCLK_OK_O)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase number, cycles spent in it, retries, latched mask,
    // and per-refclk edge tallies over the current window.
    int             m_st;
    int             m_t;
    int             m_retry;
    logic [NLB-1:0] m_mask;
    int             m_edges[NR];
    int             m_win;
    logic [NR-1:0]  m_ok;
    logic [NR-1:0]  m_prev;

    // Environment: refclk toggle periods, lock/resetdone latencies.
    int             tgl_period[NR];
    int             tgl_cnt[NR];
    int             lock_delay;
    int             lock_cnt;
    int             done_delay;
    int             done_cnt[NLB];
    logic [NLB-1:0] done_en;

    // Observation helpers.
    int             trace;
    int             last_obs;
    int             lock_timeouts;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int  nst;
        bit  go_retry;
        if (rst) begin
            m_st = 0; m_t = 0; m_retry = 0; m_mask = '0;
            m_win = 0; m_ok = '0; m_prev = '0;
            for (int r = 0; r < NR; r++) m_edges[r] = 0;
            return;
        end
        nst = m_st;
        go_retry = 1'b0;
        if (!start) begin
            nst = 0;
        end else begin
            case (m_st)
                0: begin nst = 1; m_mask = mask_in; end
                1: if (&m_ok) nst = 2;
                2: if (m_t == RSTC - 1) nst = 3;
                3: if (&lock) nst = 4; else if (m_t == LTO - 1) go_retry = 1'b1;
                4: if (m_t == RSTC - 1) nst = 5;
                5: if ((done & m_mask) == m_mask) nst = 6;
                   else if (m_t == DTO - 1) go_retry = 1'b1;
                6: if (!(&lock) || !(&m_ok)) go_retry = 1'b1;
                default: ;
            endcase
        end
        if (go_retry) begin
            if (m_retry < MAXR) begin m_retry++; nst = 2; end
            else nst = 7;
        end
        if (nst == 0) m_retry = 0;
        m_t  = (nst != m_st) ? 0 : m_t + 1;
        m_st = nst;
        // Refclk windows advance after the sequencer has used the old status.
        for (int r = 0; r < NR; r++) begin
            int e;
            e = (tgl[r] != m_prev[r]) ? 1 : 0;
            if (m_win == WIN - 1) begin
                m_ok[r]    = (m_edges[r] >= MINE);
                m_edges[r] = e;
            end else begin
                m_edges[r] = (m_edges[r] + e > MINE) ? MINE : m_edges[r] + e;
            end
        end
        m_prev = tgl;
        m_win  = (m_win + 1) % WIN;
    endtask

    task automatic env_update();
        for (int r = 0; r < NR; r++) begin
            if (tgl_period[r] > 0) begin
                tgl_cnt[r]++;
                if (tgl_cnt[r] >= tgl_period[r]) begin
                    tgl_cnt[r] = 0;
                    tgl[r] = ~tgl[r];
                end
            end
        end
        if (PLL_RESET_O[0]) lock_cnt = 0;
        else if (lock_cnt < 1000000) lock_cnt++;
        lock[0] = (lock_cnt >= lock_delay);
        for (int l = 0; l < NLB; l++) begin
            if (GT_RESET_O[l]) done_cnt[l] = 0;
            else if (done_cnt[l] < 1000000) done_cnt[l]++;
            done[l] = (done_cnt[l] >= done_delay) && done_en[l];
        end
    endtask

    task automatic tick();
        logic [NQ-1:0]  e_pll;
        logic [NLB-1:0] e_gt;
        logic [NLB-1:0] e_tx;
        @(posedge clk);
        model_step();
        #1;
        e_pll = (m_st >= 3 && m_st <= 6) ? '0 : '1;
        e_gt  = (m_st == 5 || m_st == 6) ? ~m_mask : '1;
        e_tx  = (m_st == 6) ? m_mask : '0;
        check_eq("state", 32'(STATE_O), 32'(m_st));
        check_eq("pll_reset", 32'(PLL_RESET_O), 32'(e_pll));
        check_eq("gt_reset", 32'(GT_RESET_O), 32'(e_gt));
        check_eq("tx_en", 32'(TX_EN_O), 32'(e_tx));
        check_eq("ready", 32'(READY_O), 32'(m_st == 6));
        check_eq("fail", 32'(FAIL_O), 32'(m_st == 7));
        check_eq("retry_cnt", 32'(RETRY_CNT_O), 32'(m_retry));
        check_eq("refclk_ok", 32'(REFCLK_OK_O), 32'(m_ok));
        if (32'(STATE_O) != last_obs) begin
            trace = (trace << 4) | 32'(STATE_O);
            if (last_obs == 3 && (STATE_O == 3'd2 || STATE_O == 3'd7)) lock_timeouts++;
        end
        last_obs = 32'(STATE_O);
        env_update();
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int n;
        n = 0;
        while (32'(STATE_O) != s && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(STATE_O), 32'(s));
    endtask

    task automatic go_idle();
        start = 1'b0;
        tick();
        check_eq("idle_state", 32'(STATE_O), 32'd0);
        check_eq("idle_retry", 32'(RETRY_CNT_O), 32'd0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; mask_in = '0; tgl = '0; lock = '0; done = '0;
        for (int r = 0; r < NR; r++) begin tgl_period[r] = 4; tgl_cnt[r] = 0; end
        for (int l = 0; l < NLB; l++) done_cnt[l] = 0;
        lock_delay = 100; lock_cnt = 0; done_delay = 50; done_en = '1;
        trace = 0; last_obs = 0; lock_timeouts = 0;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("rst_state", 32'(STATE_O), 32'd0);
        check_eq("rst_pll", 32'(PLL_RESET_O), 32'h1);
        check_eq("rst_gt", 32'(GT_RESET_O), 32'hf);
        check_eq("rst_refclk_ok", 32'(REFCLK_OK_O), 32'h0);

        // Healthy bring-up.
        mask_in = 4'b0101;
        trace = 0;
        start = 1'b1;
        wait_state(6, 2000, "healthy_run");
        check_eq("healthy_seq", 32'(trace), 32'h123456);
        check_eq("healthy_tx", 32'(TX_EN_O), 32'h5);
        check_eq("healthy_ready", 32'(READY_O), 32'h1);
        check_eq("healthy_retry", 32'(RETRY_CNT_O), 32'h0);

        // Mask change while running is ignored.
        mask_in = 4'b1010;
        repeat (5) tick();
        check_eq("mask_hold_tx", 32'(TX_EN_O), 32'h5);

        // One-cycle lock loss in RUN.
        lock = '0;
        tick();
        check_eq("lockloss_tx", 32'(TX_EN_O), 32'h0);
        check_eq("lockloss_retry", 32'(RETRY_CNT_O), 32'h1);
        check_eq("lockloss_state", 32'(STATE_O), 32'h2);
        cnt = (PLL_RESET_O == 1'b1) ? 1 : 0;
        while (STATE_O == 3'd2 && cnt < 100) begin
            tick();
            if (PLL_RESET_O == 1'b1) cnt++;
        end
        check_eq("pll_rst_width", 32'(cnt), 32'd16);
        wait_state(6, 1000, "rerun");

        // Lock never asserts: four timeouts, then FAIL.
        go_idle();
        lock_delay = 1 << 30;
        lock_timeouts = 0;
        start = 1'b1;
        wait_state(7, 3000, "lock_fail_state");
        check_eq("lock_fail_flag", 32'(FAIL_O), 32'h1);
        check_eq("lock_fail_retry", 32'(RETRY_CNT_O), 32'h3);
        check_eq("lock_timeouts", 32'(lock_timeouts), 32'd4);
        repeat (10) tick();
        check_eq("fail_sticky", 32'(STATE_O), 32'h7);
        go_idle();
        lock_delay = 100;

        // Dead refclk on input 1.
        tgl_period[1] = 0;
        repeat (2 * WIN + 2) tick();
        check_eq("dead_refclk_ok", 32'(REFCLK_OK_O), 32'h1);
        start = 1'b1;
        repeat (WIN) tick();
        check_eq("dead_refclk_state", 32'(STATE_O), 32'h1);
        check_eq("dead_refclk_pll", 32'(PLL_RESET_O), 32'h1);
        tgl_period[1] = 4;
        wait_state(6, 2000, "refclk_recovered");

        // Empty mask reaches RUN with no TX lanes.
        go_idle();
        mask_in = 4'b0000;
        start = 1'b1;
        wait_state(6, 2000, "mask0_run");
        check_eq("mask0_tx", 32'(TX_EN_O), 32'h0);

        // Synchronous reset in WAIT_DONE.
        go_idle();
        mask_in = 4'b0011;
        done_en = '0;
        start = 1'b1;
        wait_state(5, 2000, "reach_wait_done");
        rst = 1'b1;
        tick();
        check_eq("rstmid_state", 32'(STATE_O), 32'h0);
        check_eq("rstmid_pll", 32'(PLL_RESET_O), 32'h1);
        check_eq("rstmid_gt", 32'(GT_RESET_O), 32'hf);
        check_eq("rstmid_tx", 32'(TX_EN_O), 32'h0);
        check_eq("rstmid_ready", 32'(READY_O), 32'h0);
        check_eq("rstmid_ok", 32'(REFCLK_OK_O), 32'h0);
        rst = 1'b0;
        done_en = '1;

        // Randomised sessions: random masks, latencies, partial resetdone, lock glitches.
        for (int k = 0; k < 8; k++) begin
            go_idle();
            mask_in    = 4'($urandom);
            lock_delay = $urandom_range(1, 260);
            done_delay = $urandom_range(1, 180);
            done_en    = ($urandom_range(0, 1) == 0) ? 4'hf : 4'($urandom);
            start = 1'b1;
            for (int c = 0; c < 700; c++) begin
                if ($urandom_range(0, 199) == 0) lock = '0;
                if ($urandom_range(0, 999) == 0) start = 1'b0;
                else start = 1'b1;
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gt_lane_bringup_ctrl.md
Name: gt_lane_bringup_ctrl

Overview:
- Parametrised bring-up sequencer for 7-series GT quads. Generalises the fixed 2-bit, tied-off TX enable into per-lane, mask-driven TX enables.
- Checks refclk activity, sequences PLL reset/lock and GT reset/resetdone, then enables TX on selected lanes.
- Retries on timeout or loss of lock, up to a limit, then latches a failure.
- Sits in the IBERT/GT example top between the refclk IBUFDS outputs and the transceiver core.

Parameters:
- NUM_QUADS, 1: number of GT quads; lane count NL = 4*NUM_QUADS.
- NUM_REFCLKS, 1: number of monitored refclks.
- REFCLK_WIN, 1024: SYSCLK cycles per refclk activity window.
- REFCLK_MIN_EDGES, 16: minimum toggle edges per window for a refclk to count as alive.
- RST_CYC, 16: width of the PLL and GT reset pulses, in cycles.
- LOCK_TIMEOUT, 65536: maximum wait for PLL lock, in cycles.
- DONE_TIMEOUT, 65536: maximum wait for resetdone, in cycles.
- MAX_RETRY, 3: number of retries before FAIL.

Ports:
- SYSCLK_I  in  1  system clock; all logic is in this domain.
- RST_I  in  1  synchronous reset, active-high.
- START_I  in  1  level; high requests bring-up, low returns the block to IDLE.
- LANE_MASK_I  in  NL  lanes to bring up.
- REFCLK_TGL_I  in  NUM_REFCLKS  divided refclk toggles, already synchronised to SYSCLK_I.
- PLL_LOCK_I  in  NUM_QUADS  per-quad PLL lock.
- RESETDONE_I  in  NL  per-lane GT resetdone.
- PLL_RESET_O  out  NUM_QUADS  per-quad PLL reset.
- GT_RESET_O  out  NL  per-lane GT reset.
- TX_EN_O  out  NL  per-lane TX enable.
- STATE_O  out  3  current FSM state.
- READY_O  out  1  high while in RUN.
- FAIL_O  out  1  high while in FAIL.
- RETRY_CNT_O  out  4  retries used so far.
- REFCLK_OK_O  out  NUM_REFCLKS  per-refclk activity status.

Behaviour:
- Clock and reset: single clock SYSCLK_I. RST_I is synchronous and active-high.
- Reset values: STATE_O=0, PLL_RESET_O all 1, GT_RESET_O all 1, TX_EN_O=0, READY_O=0, FAIL_O=0, RETRY_CNT_O=0, REFCLK_OK_O=0.
- Refclk monitor:
  - Edge = REFCLK_TGL_I XOR its registered copy.
  - Per-refclk edge counter saturates at REFCLK_MIN_EDGES.
  - A free-running window counter wraps every REFCLK_WIN cycles. On wrap, REFCLK_OK_O[i] <= (count[i] >= REFCLK_MIN_EDGES) and all edge counters clear.
  - Any edge in the wrap cycle counts toward the next window.
- FSM states: IDLE=0, WAIT_REFCLK=1, PLL_RST=2, WAIT_LOCK=3, GT_RST=4, WAIT_DONE=5, RUN=6, FAIL=7. Outputs are registered and change in the same cycle as STATE_O.
- IDLE: all resets asserted, TX_EN_O=0, retry count cleared. START_I=1 latches LANE_MASK_I into the internal mask and goes to WAIT_REFCLK.
- WAIT_REFCLK: waits until all REFCLK_OK_O are 1 (no timeout), then goes to PLL_RST.
- PLL_RST: PLL_RESET_O all 1 for exactly RST_CYC cycles, then WAIT_LOCK.
- WAIT_LOCK: PLL_RESET_O=0.
  - All PLL_LOCK_I high goes to GT_RST.
  - Timer reaching LOCK_TIMEOUT triggers a retry.
- GT_RST: GT_RESET_O = mask for RST_CYC cycles (unmasked lanes stay at 1), then WAIT_DONE.
- WAIT_DONE: GT_RESET_O = ~mask.
  - (RESETDONE_I & mask) == mask goes to RUN.
  - Timer reaching DONE_TIMEOUT triggers a retry.
  - With mask=0 the condition is met immediately.
- RUN: TX_EN_O = mask, READY_O=1. Loss of any PLL_LOCK_I or any REFCLK_OK_O triggers a retry.
- Retry:
  - If RETRY_CNT_O < MAX_RETRY: increment it, drop TX_EN_O, go to PLL_RST.
  - Otherwise go to FAIL.
- FAIL: all resets asserted, TX_EN_O=0, FAIL_O=1. The block stays here until START_I=0.
- START_I=0 in any state goes to IDLE on the next cycle. This has priority over every other transition.
- The timer clears on every state entry. RST_I mid-sequence returns all outputs to their reset values the next cycle.

Decomposition:
- Package gt_bringup_pkg holds:
  - the state enum;
  - localparam NL;
  - timer width = $clog2(max(LOCK_TIMEOUT, DONE_TIMEOUT)) + 1.
- Sub-module refclk_activity_mon implements the toggle counters and window and is instantiated once per refclk. The FSM stays in the top module.

Test Plan:
- Healthy bring-up: NUM_QUADS=1, mask=4'b0101, refclk toggling every 4 cycles, lock 100 cycles after PLL reset release, resetdone 50 cycles later -> state sequence 1..6, TX_EN_O=4'b0101, READY_O=1, RETRY_CNT_O=0.
- Dead refclk: REFCLK_TGL_I stuck -> REFCLK_OK_O=0 after the first window, FSM held in WAIT_REFCLK, PLL_RESET_O=1.
- Lock never asserts: MAX_RETRY=3 -> four LOCK_TIMEOUT expiries, RETRY_CNT_O 0->3, then STATE_O=7 and FAIL_O=1. Dropping START_I -> IDLE with RETRY_CNT_O=0.
- Lock loss in RUN: PLL_LOCK_I drops for 1 cycle -> TX_EN_O=0 next cycle, RETRY_CNT_O=1, FSM back in PLL_RST, PLL_RESET_O high for exactly 16 cycles.
- Mask changed mid-run: LANE_MASK_I changes in RUN -> TX_EN_O unchanged. mask=0 -> RUN reached with TX_EN_O=0.
- RST_I pulse in WAIT_DONE -> next cycle STATE_O=0, all resets asserted, all other outputs at reset values.
